// File: rtl/cfg_ctrl_pkg.sv
// cfg_ctrl_pkg: FSM states and CRC-16-CCITT constants shared by the config chain loader.
package cfg_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, COMMIT} cfg_state_e;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
endpackage

// File: rtl/cfg_crc16_serial.sv
// cfg_crc16_serial: bit-serial MSB-first CRC-16-CCITT, one input bit per enabled cycle.
module cfg_crc16_serial
  import cfg_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  logic w_fb;
  assign w_fb = crc[15] ^ din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= '0;
    else if (clr) crc <= CRC16_INIT;
    else if (en) crc <= {crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises config words LSB-first onto the tile chain, then pulses set.
// Define CFG_CRC_EN to add a CRC-16 over the bits returned from the end of the chain.
module cfg_chain_loader
  import cfg_ctrl_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_cen,
  output logic              cfg_shift,
  output logic              cfg_set,
  input  logic              cfg_shift_ret,
  output logic              busy,
  output logic              done,
  output logic [15:0]       crc_out
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  cfg_state_e        r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [WB_W-1:0]   r_wbits;
  logic [WORD_W-1:0] r_sreg;
  logic              r_done;
  logic              w_short;
  // the last word may carry fewer live bits than WORD_W; the rest are dropped
  assign w_short = 32'(r_rem) < WORD_W;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_wbits <= '0;
      r_sreg  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) r_state <= IDLE;
      else
        case (r_state)
          IDLE: if (start) begin
            r_state <= FETCH;
            r_rem   <= CNT_W'(CHAIN_LEN);
          end
          FETCH: if (word_valid) begin
            r_sreg  <= word_data;
            r_wbits <= w_short ? WB_W'(r_rem) : WB_W'(WORD_W);
            r_state <= SHIFT;
          end
          SHIFT: begin
            r_sreg  <= r_sreg >> 1;
            r_wbits <= r_wbits - WB_W'(1);
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= (r_rem == CNT_W'(1)) ? COMMIT : (r_wbits == WB_W'(1)) ? FETCH : SHIFT;
          end
          COMMIT: begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        endcase
    end
  assign word_ready = (r_state == FETCH) && !abort;
  assign cfg_cen    = r_state == SHIFT;
  assign cfg_shift  = cfg_cen && r_sreg[0];
  assign cfg_set    = r_state == COMMIT;
  assign busy       = r_state != IDLE;
  assign done       = r_done;
`ifdef CFG_CRC_EN
  cfg_crc16_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((r_state == IDLE) && start && !abort),
    .en    (cfg_cen),
    .din   (cfg_shift_ret),
    .crc   (crc_out)
  );
`else
  logic w_unused;
  assign w_unused = cfg_shift_ret;
  assign crc_out  = 16'h0000;
`endif
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: scoreboard bench; driver queues expected chain bits, monitor checks them.
module tb_cfg_chain_loader;
  localparam int W = 32, L = 40;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic         start = 1'b0, abort = 1'b0, word_valid = 1'b0, cfg_shift_ret;
  logic [W-1:0] word_data = '0;
  logic         word_ready, cfg_cen, cfg_shift, cfg_set, busy, done;
  logic [15:0]  crc_out;
  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .cfg_cen(cfg_cen), .cfg_shift(cfg_shift),
    .cfg_set(cfg_set), .cfg_shift_ret(cfg_shift_ret), .busy(busy), .done(done), .crc_out(crc_out)
  );
  logic         s_start = 1'b0, s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         a_rdy, a_cen, a_sh, a_set, a_busy, a_done, b_rdy, b_cen, b_sh, b_set, b_busy, b_done;
  logic [15:0]  a_crc, b_crc;
  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .word_data(s_data),
    .word_valid(s_valid), .word_ready(a_rdy), .cfg_cen(a_cen), .cfg_shift(a_sh),
    .cfg_set(a_set), .cfg_shift_ret(1'b0), .busy(a_busy), .done(a_done), .crc_out(a_crc)
  );
  cfg_chain_loader #(.WORD_W(W), .CHAIN_LEN(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0), .word_data(s_data),
    .word_valid(s_valid), .word_ready(b_rdy), .cfg_cen(b_cen), .cfg_shift(b_sh),
    .cfg_set(b_set), .cfg_shift_ret(1'b0), .busy(b_busy), .done(b_done), .crc_out(b_crc)
  );

  int n_tot = 0, n_pass = 0;
  int cyc = 0, t_start = 0, exp_lat = 0, rem_m = 0, exp_set = 0, n_acc = 0, loads_done = 0;
  logic exp_done = 1'b0;
  logic [15:0] crc_m = 16'hFFFF;
  logic q[$];
  // environment model of the tile chain: last tile's shift_out feeds back
  logic [L-1:0] chain = 40'h12_3456_789A;
  assign cfg_shift_ret = chain[L-1];
  always @(posedge clk) if (cfg_cen) chain <= {chain[L-2:0], cfg_shift};
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return (c << 1) ^ (((c >> 15) & 16'h1) != {15'd0, d} ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [4:0] small_exp(input int len, input int c, input logic [W-1:0] w);
    logic cen = c >= 1 && c <= len;
    int   idx = cen ? c - 1 : 0;
    return {c == 0, cen, cen && w[idx], c == len + 1, c == len + 2};
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (word_valid && word_ready) n_acc++;
    if (cfg_cen) begin
      if (q.size() == 0) chk("extra_bit", 1, 0);
      else chk("bit", cfg_shift, q.pop_front());
      crc_m = crc_step(crc_m, cfg_shift_ret);
    end
    if (done || exp_done) chk("done", done, exp_done);
    if (done) begin
      loads_done++;
`ifdef CFG_CRC_EN
      chk("crc", crc_out, crc_m);
`else
      chk("crc_zero", crc_out, 0);
`endif
    end
    exp_done = 1'b0;
    if (cfg_set) begin
      chk("set_expected", exp_set > 0 && q.size() == 0, 1);
      chk("set_cen", cfg_cen, 0);
      chk("latency", cyc - t_start, exp_lat);
      if (exp_set > 0) exp_set--;
      exp_done = 1'b1;
    end
  end

  task automatic do_start;
    start = 1'b1; rem_m = L; crc_m = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0; t_start = cyc;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int stall);
    logic hs = 1'b0;
    int   n;
    if (stall > 0) begin
      word_valid = 1'b0;
      for (int t = 0; t < 200; t++) begin @(negedge clk); if (word_ready) break; end
      repeat (stall) begin @(posedge clk); #1; end
    end
    word_valid = 1'b1; word_data = w;
    for (int t = 0; t < 200 && !hs; t++) begin
      @(negedge clk); hs = word_ready;
      @(posedge clk); #1;
    end
    if (!hs) chk("handshake_timeout", 0, 1);
    n = rem_m < W ? rem_m : W;
    for (int i = 0; i < n; i++) q.push_back(w[i]);
    rem_m -= n;
    if (rem_m == 0) exp_set++;
  endtask

  task automatic wait_done;
    int d0 = loads_done;
    for (int t = 0; t < 300 && loads_done == d0; t++) @(posedge clk);
    #1;
    if (loads_done == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic load(input logic [W-1:0] w0, input logic [W-1:0] w1, input int st0, input int st1, input bit poke);
    exp_lat = L + 2 + st0 + st1;
    do_start;
    send_word(w0, st0);
    if (poke) begin
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
    end
    send_word(w1, st1);
    wait_done;
    word_valid = 1'b0;
  endtask

  initial begin
    logic [L-1:0] s, exp_chain;
    logic [W-1:0] w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {word_ready, cfg_cen, cfg_shift, cfg_set, busy, done, crc_out}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    // basic load, then valid held high: a third word must not be taken
    n_acc = 0;
    load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, 1'b0);
    word_valid = 1'b1; word_data = 32'hDEAD_BEEF;
    repeat (6) begin @(posedge clk); #1; end
    chk("words_consumed", n_acc, 2);
    word_valid = 1'b0;
`ifdef CFG_CRC_EN
    s = {8'hC3, 32'hA5A5_0F0F};
    for (int k = 0; k < L; k++) exp_chain[L-1-k] = s[k];
    chk("chain_contents", chain, exp_chain);
`endif
    // starved second word, with a start pulse while busy
    load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 10, 1'b1);
    for (int r = 0; r < 4; r++) load($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 5), r[0]);
    // abort after 20 shifted bits
    exp_lat = 0;
    do_start;
    send_word($urandom, 0);
    repeat (19) begin @(posedge clk); #1; end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    q.delete(); exp_set = 0; rem_m = 0; word_valid = 1'b0;
    @(negedge clk); chk("abort_busy", {busy, cfg_cen}, 0);
    repeat (45) @(posedge clk); #1;
    load($urandom, $urandom, 0, 0, 1'b0);
    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk); chk("start_abort_idle", busy, 0);
    @(posedge clk); #1;
    // abort in FETCH with a valid word: not consumed
    n_acc = 0;
    do_start;
    word_valid = 1'b1; word_data = $urandom; abort = 1'b1;
    @(negedge clk); chk("abort_ready", word_ready, 0);
    @(posedge clk); #1; abort = 1'b0; word_valid = 1'b0;
    @(negedge clk); chk("abort_fetch_busy", busy, 0);
    chk("abort_fetch_acc", n_acc, 0);
    @(posedge clk); #1;
    // async reset mid-SHIFT
    do_start;
    send_word($urandom, 0);
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    chk("reset_mid_shift", {word_ready, cfg_cen, cfg_shift, cfg_set, busy, done, crc_out}, 0);
    q.delete(); exp_set = 0; rem_m = 0; word_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    load($urandom, $urandom, 1, 2, 1'b0);
    // CHAIN_LEN=1 and CHAIN_LEN=32 instances side by side
    w = $urandom;
    s_start = 1'b1; @(posedge clk); #1; s_start = 1'b0; s_valid = 1'b1; s_data = w;
    for (int c = 0; c <= 35; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      chk("len1", {a_rdy, a_cen, a_sh, a_set, a_done}, small_exp(1, c, w));
      chk("len32", {b_rdy, b_cen, b_sh, b_set, b_done}, small_exp(32, c, w));
    end
    s_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
